program_loader: RTL and testbench

- Sequences byte-wide writes into the instruction byte RAM (`program_memory` write port) from a UART receive byte stream.
- Holds the CPU core while loading; releases it only after a verified load.
- Sits between the UART RX block, the program memory write port and the core's reset/stall input.
- Frame format: 4-byte little-endian length, payload bytes, 1-byte checksum (payload sum mod 256).

---
 rtl/program_loader.sv | 132 +++++++++++++
 tb/tb_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART-fed program memory loader that holds the core until a verified load
module program_loader #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_write_enable,
  output logic [7:0]  mem_write_data,
  output logic [31:0] mem_write_address,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, DONE, ERROR} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  len_index;
  logic [31:0] length;
  logic [31:0] byte_index;
  logic [31:0] timeout_count;
  logic [7:0]  checksum;
  logic [31:0] length_full;
  logic        in_frame;
  logic        at_rest;
  logic        timed_out;

  // Length as it will be once the byte currently on rx_data (the MSB) is shifted in.
  assign length_full = {rx_data, length[23:0]};
  assign in_frame    = (state == LEN) || (state == LOAD) || (state == CHECK);
  assign at_rest     = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign timed_out   = in_frame && !rx_valid && (timeout_count == TIMEOUT_CYCLES - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; status outputs are pure functions of the state.
  always_comb begin
    state_next = state;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) state_next = LEN;
      end
      LEN: begin
        if (timed_out) begin
          state_next = ERROR;
        end else if (rx_valid && (len_index == 2'd3)) begin
          if (length_full > MEM_BYTES) state_next = ERROR;
          else if (length_full == 32'd0) state_next = CHECK;
          else state_next = LOAD;
        end
      end
      LOAD: begin
        if (timed_out) state_next = ERROR;
        else if (rx_valid && (byte_index == length - 32'd1)) state_next = CHECK;
      end
      CHECK: begin
        if (timed_out) state_next = ERROR;
        else if (rx_valid) state_next = (rx_data == checksum) ? DONE : ERROR;
      end
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (load_req) state_next = LEN;
      end
      ERROR: begin
        load_error = 1'b1;
        if (load_req) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: length capture, byte index, checksum, idle timer and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_index         <= 2'd0;
      length            <= 32'd0;
      byte_index        <= 32'd0;
      timeout_count     <= 32'd0;
      checksum          <= 8'd0;
      mem_write_enable  <= 1'b0;
      mem_write_data    <= 8'd0;
      mem_write_address <= 32'd0;
    end else begin
      mem_write_enable <= 1'b0;
      if (at_rest && load_req) begin
        // A new frame starts from a clean slate; a byte arriving with load_req is dropped.
        len_index     <= 2'd0;
        length        <= 32'd0;
        byte_index    <= 32'd0;
        timeout_count <= 32'd0;
        checksum      <= 8'd0;
      end else if (in_frame) begin
        if (rx_valid) timeout_count <= 32'd0;
        else timeout_count <= timeout_count + 32'd1;
        if (rx_valid) begin
          case (state)
            LEN: begin
              length[{len_index, 3'b000} +: 8] <= rx_data;
              len_index <= len_index + 2'd1;
            end
            LOAD: begin
              mem_write_enable  <= 1'b1;
              mem_write_data    <= rx_data;
              mem_write_address <= BASE_ADDR + byte_index;
              byte_index        <= byte_index + 32'd1;
              checksum          <= checksum + rx_data;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_write_enable;
  logic [7:0]  mem_write_data;
  logic [31:0] mem_write_address;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  program_loader #(
    .MEM_BYTES(1024),
    .BASE_ADDR(32'd0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_req(load_req),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data),
    .mem_write_address(mem_write_address),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error)
  );

  // Count every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) wr_count++;
  end

  task automatic drive(input logic lr, input logic v, input logic [7:0] d);
    @(negedge clk);
    load_req = lr;
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic start_frame(input logic [31:0] len);
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, len[8*i +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", load_done); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", load_error); end
    n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_write_enable); end
    n_cmp++; if (mem_write_data !== 8'h00) begin n_fail++; $display("FAIL reset_wd: got %h want 00", mem_write_data); end
    n_cmp++; if (mem_write_address !== 32'h0) begin n_fail++; $display("FAIL reset_wa: got %h want 0", mem_write_address); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_ignored();
    int w0;
    w0 = wr_count;
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h13);
    drive(1'b0, 1'b1, 8'h13);
    settle();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b want 0", load_done); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL idle_error: got %b want 0", load_error); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL idle_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_normal_load();
    logic [7:0] pay [4];
    int w0;
    pay = '{8'h13, 8'h05, 8'h50, 8'h00};
    w0 = wr_count;
    start_frame(32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, pay[i]);
      settle();
      n_cmp++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL normal_we[%0d]: got %b want 1", i, mem_write_enable); end
      n_cmp++; if (mem_write_data !== pay[i]) begin n_fail++; $display("FAIL normal_wd[%0d]: got %h want %h", i, mem_write_data, pay[i]); end
      n_cmp++; if (mem_write_address !== 32'(i)) begin n_fail++; $display("FAIL normal_wa[%0d]: got %h want %h", i, mem_write_address, i); end
      drive(1'b0, 1'b0, 8'h00);
      settle();
      n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL normal_we_gap[%0d]: got %b want 0", i, mem_write_enable); end
    end
    drive(1'b0, 1'b1, 8'h68);
    settle();
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL normal_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL normal_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL normal_error: got %b want 0", load_error); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 4) begin n_fail++; $display("FAIL normal_writes: got %0d want 4", wr_count - w0); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] pay [4];
    int w0;
    pay = '{8'h13, 8'h05, 8'h50, 8'h00};
    w0 = wr_count;
    drive(1'b1, 1'b0, 8'h00);
    settle();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badck_hold_rise: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL badck_done_clr: got %b want 0", load_done); end
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, pay[i]);
    drive(1'b0, 1'b1, 8'h69);
    settle();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL badck_error: got %b want 1", load_error); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badck_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL badck_done: got %b want 0", load_done); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 4) begin n_fail++; $display("FAIL badck_writes: got %0d want 4", wr_count - w0); end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_count;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h00);
    settle();
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL over_mid_error: got %b want 0", load_error); end
    drive(1'b0, 1'b1, 8'h00);
    settle();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL over_error: got %b want 1", load_error); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL over_hold: got %b want 1", cpu_hold); end
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL over_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_zero_length();
    int w0;
    w0 = wr_count;
    start_frame(32'd0);
    settle();
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL zero_error: got %b want 0", load_error); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL zero_early_done: got %b want 0", load_done); end
    drive(1'b0, 1'b1, 8'h00);
    settle();
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %b want 0", cpu_hold); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay [8];
    int w0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    w0 = wr_count;
    start_frame(32'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, pay[i]);
      settle();
      n_cmp++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b want 1", i, mem_write_enable); end
      n_cmp++; if (mem_write_data !== pay[i]) begin n_fail++; $display("FAIL b2b_wd[%0d]: got %h want %h", i, mem_write_data, pay[i]); end
      n_cmp++; if (mem_write_address !== 32'(i)) begin n_fail++; $display("FAIL b2b_wa[%0d]: got %h want %h", i, mem_write_address, i); end
    end
    drive(1'b0, 1'b1, 8'h64);
    settle();
    n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_we_ck: got %b want 0", mem_write_enable); end
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", load_done); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 8) begin n_fail++; $display("FAIL b2b_writes: got %0d want 8", wr_count - w0); end
  endtask

  task automatic test_load_req_mid_load();
    int w0;
    w0 = wr_count;
    start_frame(32'd4);
    drive(1'b0, 1'b1, 8'hA1);
    settle();
    drive(1'b1, 1'b0, 8'h00);
    settle();
    n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL midreq_we: got %b want 0", mem_write_enable); end
    drive(1'b1, 1'b1, 8'hB2);
    settle();
    n_cmp++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL midreq_we1: got %b want 1", mem_write_enable); end
    n_cmp++; if (mem_write_data !== 8'hB2) begin n_fail++; $display("FAIL midreq_wd1: got %h want b2", mem_write_data); end
    n_cmp++; if (mem_write_address !== 32'd1) begin n_fail++; $display("FAIL midreq_wa1: got %h want 1", mem_write_address); end
    drive(1'b0, 1'b1, 8'hC3);
    settle();
    n_cmp++; if (mem_write_address !== 32'd2) begin n_fail++; $display("FAIL midreq_wa2: got %h want 2", mem_write_address); end
    drive(1'b0, 1'b1, 8'hD4);
    settle();
    n_cmp++; if (mem_write_address !== 32'd3) begin n_fail++; $display("FAIL midreq_wa3: got %h want 3", mem_write_address); end
    n_cmp++; if (mem_write_data !== 8'hD4) begin n_fail++; $display("FAIL midreq_wd3: got %h want d4", mem_write_data); end
    drive(1'b0, 1'b1, 8'hEA);
    settle();
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL midreq_done: got %b want 1", load_done); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 4) begin n_fail++; $display("FAIL midreq_writes: got %0d want 4", wr_count - w0); end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wr_count;
    start_frame(32'd4);
    drive(1'b0, 1'b1, 8'h01);
    settle();
    drive(1'b0, 1'b1, 8'h02);
    settle();
    idle(15);
    settle();
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0 after 15 idle", load_error); end
    settle();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b want 1 after 16 idle", load_error); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL tmo_hold: got %b want 1", cpu_hold); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 2) begin n_fail++; $display("FAIL tmo_writes: got %0d want 2", wr_count - w0); end
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    w0 = wr_count;
    start_frame(32'd4);
    drive(1'b0, 1'b1, 8'h5A);
    settle();
    drive(1'b0, 1'b1, 8'h6B);
    settle();
    @(negedge clk);
    rst = 1'b1; load_req = 1'b0; rx_valid = 1'b1; rx_data = 8'h7C;
    settle();
    n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b want 0", mem_write_enable); end
    n_cmp++; if (mem_write_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_wd: got %h want 00", mem_write_data); end
    n_cmp++; if (mem_write_address !== 32'h0) begin n_fail++; $display("FAIL rstmid_wa: got %h want 0", mem_write_address); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", load_done); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_error: got %b want 0", load_error); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h8D);
    drive(1'b0, 1'b1, 8'h9E);
    settle();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_done: got %b want 0", load_done); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 2) begin n_fail++; $display("FAIL rstmid_writes: got %0d want 2", wr_count - w0); end
  endtask

  task automatic test_reload_from_done();
    int w0;
    start_frame(32'd1);
    drive(1'b0, 1'b1, 8'h5E);
    drive(1'b0, 1'b1, 8'h5E);
    settle();
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_pre_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reload_pre_hold: got %b want 0", cpu_hold); end
    w0 = wr_count;
    drive(1'b1, 1'b1, 8'hAA);
    settle();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reload_hold_rise: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reload_done_clr: got %b want 0", load_done); end
    n_cmp++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reload_we: got %b want 0", mem_write_enable); end
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'hAB);
    settle();
    n_cmp++; if (mem_write_data !== 8'hAB) begin n_fail++; $display("FAIL reload_wd0: got %h want ab", mem_write_data); end
    n_cmp++; if (mem_write_address !== 32'd0) begin n_fail++; $display("FAIL reload_wa0: got %h want 0", mem_write_address); end
    drive(1'b0, 1'b1, 8'hCD);
    settle();
    n_cmp++; if (mem_write_data !== 8'hCD) begin n_fail++; $display("FAIL reload_wd1: got %h want cd", mem_write_data); end
    n_cmp++; if (mem_write_address !== 32'd1) begin n_fail++; $display("FAIL reload_wa1: got %h want 1", mem_write_address); end
    drive(1'b0, 1'b1, 8'h78);
    settle();
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reload_hold: got %b want 0", cpu_hold); end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++; if (wr_count - w0 !== 2) begin n_fail++; $display("FAIL reload_writes: got %0d want 2", wr_count - w0); end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_normal_load();
    test_bad_checksum();
    test_oversize();
    test_zero_length();
    test_back_to_back();
    test_load_req_mid_load();
    test_timeout();
    test_reset_mid_frame();
    test_reload_from_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
